// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: free round-robin, or one producer holding a burst lock.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fifo_arb_state_t;

  // Width of the priority pointer / requester index (never less than 1 bit).
  function automatic int ARB_PTR_W(input int requesters);
    return (requesters > 1) ? $clog2(requesters) : 1;
  endfunction

endpackage

// File: rtl/module_rr_select.sv
// Combinational rotating-priority picker: returns the first set bit of
// mask scanning ptr, ptr+1, ... with wrap-around, as one-hot and index.
module module_rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              mask,
  input  logic [ARB_PTR_W(N)-1:0]   ptr,
  output logic [N-1:0]              onehot,
  output logic [ARB_PTR_W(N)-1:0]   idx,
  output logic                      valid
);

  localparam int PW = ARB_PTR_W(N);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      sum = {1'b0, ptr} + (PW+1)'(j);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end else begin
        sum = sum;
      end
      cand = sum[PW-1:0];
      if (mask[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
        valid        = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/module_fifo_arbiter.sv
// Round-robin write-port arbiter in front of a single module_fifo.
// Optional burst lock is compiled in with `define FIFO_ARB_LOCK_EN;
// without it the lock input is ignored and arbitration is pure round-robin.
module module_fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REQUESTERS = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQUESTERS-1:0] req,
  input  logic [REQUESTERS-1:0] lock,
  input  logic [XLEN-1:0]       din [REQUESTERS],
  output logic [REQUESTERS-1:0] grant,
  input  logic                  fifo_full,
  output logic                  fifo_we,
  output logic [XLEN-1:0]       fifo_din
);

  localparam int PW = ARB_PTR_W(REQUESTERS);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [REQUESTERS-1:0] mask_s;
  logic [REQUESTERS-1:0] sel_onehot_s;
  logic [PW-1:0]         sel_idx_s;
  logic                  sel_valid_s;
  logic                  accept_s;
  logic [PW-1:0]         nxt_ptr_s;

`ifdef FIFO_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  fifo_arb_state_t       state_q, state_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [PW-1:0]         owner_nxt_s;

  // While locked only the owner's request is eligible.
  always_comb begin
    mask_s = req;
    if (state_q == LOCKED) begin
      mask_s = '0;
      mask_s[owner_q] = req[owner_q];
    end else begin
      mask_s = req;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^lock;

  // Every requester is always eligible in plain round-robin.
  always_comb begin
    mask_s = req;
  end
`endif

  module_rr_select #(
    .N (REQUESTERS)
  ) u_select (
    .mask   (mask_s),
    .ptr    (ptr_q),
    .onehot (sel_onehot_s),
    .idx    (sel_idx_s),
    .valid  (sel_valid_s)
  );

  // Same-cycle grant and write-port steering; reset and full block all writes.
  always_comb begin
    accept_s = sel_valid_s & ~fifo_full & ~reset;
    if (accept_s) begin
      grant    = sel_onehot_s;
      fifo_we  = 1'b1;
      fifo_din = din[sel_idx_s];
    end else begin
      grant    = '0;
      fifo_we  = 1'b0;
      fifo_din = '0;
    end
    if (sel_idx_s == PW'(REQUESTERS - 1)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = sel_idx_s + 1'b1;
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  // Next pointer, lock ownership and burst count; everything holds when full.
  always_comb begin
    ptr_d       = ptr_q;
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (owner_q == PW'(REQUESTERS - 1)) begin
      owner_nxt_s = '0;
    end else begin
      owner_nxt_s = owner_q + 1'b1;
    end
    if (fifo_full) begin
      ptr_d = ptr_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            ptr_d = nxt_ptr_s;
            if (lock[sel_idx_s]) begin
              state_d     = LOCKED;
              owner_d     = sel_idx_s;
              burst_cnt_d = CW'(1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        LOCKED: begin
          if (!req[owner_q]) begin
            state_d     = IDLE;
            ptr_d       = owner_nxt_s;
            burst_cnt_d = '0;
          end else if (accept_s) begin
            ptr_d = owner_nxt_s;
            if (!lock[owner_q] || (burst_cnt_q == CW'(MAX_BURST - 1))) begin
              state_d     = IDLE;
              burst_cnt_d = '0;
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        default: begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end
      endcase
    end
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      state_q     <= IDLE;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  // Pointer moves past the winner after each accepted word.
  always_comb begin
    if (accept_s) begin
      ptr_d = nxt_ptr_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_module_fifo_arbiter.sv
// Directed, table-driven bench for module_fifo_arbiter (4 requesters,
// MAX_BURST=4). Expectations for the lock sequences follow FIFO_ARB_LOCK_EN.
module tb_module_fifo_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [XLEN-1:0] din [NREQ];
  logic [NREQ-1:0] grant;
  logic            fifo_full;
  logic            fifo_we;
  logic [XLEN-1:0] fifo_din;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       full;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  module_fifo_arbiter #(
    .XLEN       (XLEN),
    .REQUESTERS (NREQ),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .din       (din),
    .grant     (grant),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, advance one edge.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] lk, input logic fl, input logic [3:0] eg);
    logic [31:0] ed;
    reset = r; req = rq; lock = lk; fifo_full = fl;
    ed = 32'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) ed = 32'hA0 + i;
    end
    #1;
    check({name, ".grant"}, {28'h0, grant}, {28'h0, eg});
    check({name, ".we"}, {31'h0, fifo_we}, {31'h0, (eg != 4'b0000)});
    check({name, ".din"}, fifo_din, ed);
    @(negedge clk);
  endtask

  vec_t vecs [18];
  logic [3:0] lk_exp [9];
  logic [3:0] lk_full;
  logic [3:0] drop_exp;

  initial begin
    for (int i = 0; i < NREQ; i++) din[i] = 32'hA0 + i;
    reset = 1'b1; req = 4'h0; lock = 4'h0; fifo_full = 1'b0;

    //           rst   req      lock     full  grant    data
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 8'h00};
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 8'h00};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 8'hA0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 8'hA1};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 8'hA2};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 8'hA3};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 8'hA0};
    vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 8'h00};
    vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 8'h00};
    vecs[9]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 8'hA2};
    vecs[10] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 8'hA0};
    vecs[11] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, 8'hA1};
    vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00};
    vecs[13] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b1000, 8'hA3};
    vecs[14] = '{1'b0, 4'b1010, 4'b0000, 1'b0, 4'b0010, 8'hA1};
    vecs[15] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 8'h00};
    vecs[16] = '{1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0010, 8'hA1};
    vecs[17] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 8'hA2};

`ifdef FIFO_ARB_LOCK_EN
    lk_exp = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0010,
               4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drop_exp = 4'b0000;
`else
    lk_exp = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    drop_exp = 4'b0001;
`endif
    lk_full = 4'd2;

    @(negedge clk);

    // Table: reset, rotation, full stall, wrap-around, idle, reset mid-stream.
    for (int v = 0; v < 18; v++) begin
      reset = vecs[v].rst; req = vecs[v].req; lock = vecs[v].lock; fifo_full = vecs[v].full;
      #1;
      check($sformatf("vec%0d.grant", v), {28'h0, grant}, {28'h0, vecs[v].exp_grant});
      check($sformatf("vec%0d.we", v), {31'h0, fifo_we}, {31'h0, (vecs[v].exp_grant != 4'b0000)});
      check($sformatf("vec%0d.din", v), fifo_din, {24'h0, vecs[v].exp_data});
      @(negedge clk);
    end

    // Burst lock by requester 1 with a full stall inside the burst.
    step("lk_rst", 1'b1, 4'b1111, 4'b0010, 1'b0, 4'b0000);
    for (int c = 0; c < 9; c++) begin
      step($sformatf("lk%0d", c), 1'b0, 4'b1111, 4'b0010,
           (c == int'(lk_full)), lk_exp[c]);
    end

    // Owner 3 locks, then drops its request while requester 0 waits.
    step("drop_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    step("drop0", 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000);
    step("drop1", 1'b0, 4'b0001, 4'b0000, 1'b0, drop_exp);
    step("drop2", 1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
